// File: rtl/sram_port_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sram_port_arbiter_if                                          |
// | Purpose  : Bundles the requester-side handshake and the SRAM command     |
// |            port of sram_port_arbiter into one interface.                 |
// | Signals  : req/req_we/req_addr/req_wdata  requester commands (packed,    |
// |            port p at [p*W +: W]); gnt/rvalid one-hot per port; rdata     |
// |            shared read data; mem_addr/mem_wdata/mem_we command to the    |
// |            SRAM interface block; mem_rdata read data from it.            |
// | Modports : slave  - the arbiter                                          |
// |            master - the requesters plus SRAM interface block             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface sram_port_arbiter_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 18
);
  logic [NUM_PORTS-1:0]        req;
  logic [NUM_PORTS-1:0]        req_we;
  logic [NUM_PORTS*ADDR_W-1:0] req_addr;
  logic [NUM_PORTS*DATA_W-1:0] req_wdata;
  logic [NUM_PORTS-1:0]        gnt;
  logic [NUM_PORTS-1:0]        rvalid;
  logic [DATA_W-1:0]           rdata;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_wdata;
  logic                        mem_we;
  logic [DATA_W-1:0]           mem_rdata;

  modport slave (
    input  req, req_we, req_addr, req_wdata, mem_rdata,
    output gnt, rvalid, rdata, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req, req_we, req_addr, req_wdata, mem_rdata,
    input  gnt, rvalid, rdata, mem_addr, mem_wdata, mem_we
  );
endinterface
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sram_port_arbiter                                             |
// | Purpose  : Round-robin sharing of one synchronous-SRAM command port      |
// |            among NUM_PORTS requesters. At most one command per clock;    |
// |            read data is routed back to the issuing port in issue order.  |
// | Ports    : clk   system clock, posedge                                   |
// |            rst   synchronous active-high reset                           |
// |            bus   sram_port_arbiter_if.slave (requester handshake + SRAM) |
// | Option   : define SRAM_ARB_TURNAROUND_EN to insert a one-cycle bubble    |
// |            when the bus direction flips on consecutive cycles.           |
// | Timing   : gnt is combinational in cycle t; the command is on mem_* in   |
// |            t+1; mem_rdata is captured at the edge ending t+READ_LATENCY, |
// |            so rvalid/rdata appear in cycle t+READ_LATENCY+1.             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sram_port_arbiter #(
  parameter int NUM_PORTS    = 2,
  parameter int ADDR_W       = 20,
  parameter int DATA_W       = 18,
  parameter int READ_LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  sram_port_arbiter_if.slave  bus
);

  localparam int PID_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  // base + offset modulo NUM_PORTS; offset never exceeds NUM_PORTS.
  function automatic logic [PID_W-1:0] next_port(input logic [PID_W-1:0] base,
                                                 input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
    return sum[PID_W-1:0];
  endfunction

  logic [PID_W-1:0]  r_ptr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_we;
  logic [NUM_PORTS-1:0] r_rvalid;
  logic [DATA_W-1:0] r_rdata;

  // Read-tag pipeline: one stage per cycle of SRAM read latency.
  logic [READ_LATENCY-1:0] r_tag_v;
  logic [PID_W-1:0]        r_tag_id [READ_LATENCY];

  logic              w_found;
  logic [PID_W-1:0]  w_winner;
  logic [PID_W-1:0]  w_cand;
  logic              w_win_we;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;
  logic              w_bubble;
  logic              w_grant;

  // Round-robin search starting at the pointer; first active request wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_ptr;
    w_cand   = r_ptr;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_cand = next_port(r_ptr, i);
      if (!w_found && bus.req[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  assign w_win_we    = bus.req_we[w_winner];
  assign w_win_addr  = bus.req_addr[int'(w_winner)*ADDR_W +: ADDR_W];
  assign w_win_wdata = bus.req_wdata[int'(w_winner)*DATA_W +: DATA_W];

`ifdef SRAM_ARB_TURNAROUND_EN
  // Remembers the direction of a command issued in the previous cycle only;
  // any cycle without a grant returns to idle, so the bubble lasts one cycle.
  typedef enum logic [1:0] {
    TA_IDLE    = 2'd0,
    TA_LAST_RD = 2'd1,
    TA_LAST_WR = 2'd2
  } ta_state_t;

  ta_state_t r_ta_state;
  ta_state_t w_ta_next;

  always_ff @(posedge clk) begin
    if (rst) r_ta_state <= TA_IDLE;
    else     r_ta_state <= w_ta_next;
  end

  always_comb begin
    w_bubble  = 1'b0;
    w_ta_next = TA_IDLE;
    if (w_found) begin
      if ((r_ta_state == TA_LAST_RD && w_win_we) ||
          (r_ta_state == TA_LAST_WR && !w_win_we)) begin
        w_bubble = 1'b1;
      end else if (!rst) begin
        w_ta_next = w_win_we ? TA_LAST_WR : TA_LAST_RD;
      end
    end
  end
`else
  assign w_bubble = 1'b0;
`endif

  // No command is accepted while reset is asserted.
  assign w_grant = w_found && !w_bubble && !rst;

  always_comb begin
    bus.gnt = '0;
    if (w_grant) bus.gnt[w_winner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_rvalid    <= '0;
      r_rdata     <= '0;
      r_tag_v     <= '0;
      for (int i = 0; i < READ_LATENCY; i++) r_tag_id[i] <= '0;
    end else begin
      // Issue: address/data hold on idle cycles, only mem_we drops.
      if (w_grant) begin
        r_mem_addr  <= w_win_addr;
        r_mem_wdata <= w_win_wdata;
        r_mem_we    <= w_win_we;
        r_ptr       <= next_port(w_winner, 1);
      end else begin
        r_mem_we    <= 1'b0;
      end

      // Writes enter the tag pipeline as empty slots so stage timing stays fixed.
      r_tag_v[0]  <= w_grant && !w_win_we;
      r_tag_id[0] <= w_winner;
      for (int i = READ_LATENCY - 1; i > 0; i--) begin
        r_tag_v[i]  <= r_tag_v[i-1];
        r_tag_id[i] <= r_tag_id[i-1];
      end

      r_rvalid <= '0;
      if (r_tag_v[READ_LATENCY-1]) begin
        r_rvalid[r_tag_id[READ_LATENCY-1]] <= 1'b1;
        r_rdata <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_we    = r_mem_we;
  assign bus.rvalid    = r_rvalid;
  assign bus.rdata     = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_sram_port_arbiter                                          |
// | Purpose  : Self-checking bench for sram_port_arbiter with a behavioural  |
// |            round-robin / read-return model and a simple SRAM model.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_sram_port_arbiter;
  localparam int NP = 4;
  localparam int AW = 20;
  localparam int DW = 18;
  localparam int RL = 2;
`ifdef SRAM_ARB_TURNAROUND_EN
  localparam bit TA_EN = 1'b1;
`else
  localparam bit TA_EN = 1'b0;
`endif
  localparam int FAIR = TA_EN ? 2*NP : NP;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_port_arbiter #(
    .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passes = 0;

  // Requester commands
  logic          p_valid [NP];
  logic          p_we    [NP];
  logic [AW-1:0] p_addr  [NP];
  logic [DW-1:0] p_wdata [NP];

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    logic [31:0] t;
    t = 32'(a) * 32'd7 + 32'd3;
    return t[DW-1:0];
  endfunction

  // SRAM model driven from the DUT's mem_* outputs; data captured at issue.
  logic [DW-1:0] sram [logic [AW-1:0]];
  logic [DW-1:0] rd_hist [RL];
  always @(negedge clk) begin
    for (int i = RL - 1; i > 0; i--) rd_hist[i] = rd_hist[i-1];
    rd_hist[0] = sram.exists(bus.mem_addr) ? sram[bus.mem_addr] : init_val(bus.mem_addr);
    if (bus.mem_we) sram[bus.mem_addr] = bus.mem_wdata;
    bus.mem_rdata = rd_hist[RL-1];
  end

  // Reference model
  typedef struct {
    int            due;
    int            port;
    logic [DW-1:0] data;
  } ret_t;
  ret_t          rq [$];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  int            cyc = 0;
  int            m_ptr = 0;
  int            m_last_cyc = -10;
  logic          m_last_we = 1'b0;
  int            e_win = -1;
  int            n_gnt [NP];
  int            waitc [NP];
  logic [NP-1:0] e_gnt, e_rvalid;
  logic [AW-1:0] e_maddr;
  logic [DW-1:0] e_mwdata, e_rdata;
  logic          e_mwe;

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_last_cyc = -10; m_last_we = 1'b0; e_win = -1;
    rq.delete();
    e_gnt = '0; e_rvalid = '0; e_maddr = '0; e_mwdata = '0; e_rdata = '0; e_mwe = 1'b0;
    for (int p = 0; p < NP; p++) begin n_gnt[p] = 0; waitc[p] = 0; end
  endtask

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      bus.req[p]                 = p_valid[p];
      bus.req_we[p]              = p_we[p];
      bus.req_addr[p*AW +: AW]   = p_addr[p];
      bus.req_wdata[p*DW +: DW]  = p_wdata[p];
    end
  endtask

  // Apply inputs for this cycle and predict the grant.
  task automatic settle();
    drive();
    #1;
    e_gnt = '0;
    e_win = -1;
    for (int i = 0; i < NP; i++) begin
      int p;
      p = (m_ptr + i) % NP;
      if (e_win < 0 && p_valid[p]) e_win = p;
    end
    if (TA_EN && e_win >= 0 && m_last_cyc == cyc - 1 && m_last_we != p_we[e_win]) e_win = -1;
    if (e_win >= 0) e_gnt[e_win] = 1'b1;
  endtask

  // Commit the predicted grant, advance one clock, predict registered outputs.
  task automatic step_edge();
    ret_t r;
    if (e_win >= 0) begin
      if (p_we[e_win]) begin
        ref_mem[p_addr[e_win]] = p_wdata[e_win];
      end else begin
        r.due = cyc + RL + 1; r.port = e_win; r.data = ref_read(p_addr[e_win]);
        rq.push_back(r);
      end
      e_mwe = p_we[e_win]; e_maddr = p_addr[e_win]; e_mwdata = p_wdata[e_win];
      m_ptr = (e_win + 1) % NP; m_last_we = p_we[e_win]; m_last_cyc = cyc;
      p_valid[e_win] = 1'b0;
      n_gnt[e_win]++;
    end else begin
      e_mwe = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    e_rvalid = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      e_rvalid[rq[0].port] = 1'b1;
      e_rdata = rq[0].data;
      void'(rq.pop_front());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int p = 0; p < NP; p++) p_valid[p] = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    cyc += 2;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.gnt !== '0) $display("FAIL reset_gnt got=%b exp=0", bus.gnt); else passes++;
    checks++; if (bus.rvalid !== '0) $display("FAIL reset_rvalid got=%b exp=0", bus.rvalid); else passes++;
    checks++; if (bus.rdata !== '0) $display("FAIL reset_rdata got=%h exp=0", bus.rdata); else passes++;
    checks++; if (bus.mem_addr !== '0) $display("FAIL reset_mem_addr got=%h exp=0", bus.mem_addr); else passes++;
    checks++; if (bus.mem_wdata !== '0) $display("FAIL reset_mem_wdata got=%h exp=0", bus.mem_wdata); else passes++;
    checks++; if (bus.mem_we !== 1'b0) $display("FAIL reset_mem_we got=%b exp=0", bus.mem_we); else passes++;
  endtask

  task automatic test_single_read();
    int t0, seen;
    do_reset();
    p_valid[0] = 1'b1; p_we[0] = 1'b0; p_addr[0] = 20'h00010; p_wdata[0] = DW'($urandom);
    settle();
    checks++; if (bus.gnt !== 4'b0001) $display("FAIL single_gnt got=%b exp=0001", bus.gnt); else passes++;
    t0 = cyc;
    step_edge();
    checks++; if (bus.mem_addr !== 20'h00010) $display("FAIL single_mem_addr got=%h exp=00010", bus.mem_addr); else passes++;
    checks++; if (bus.mem_we !== 1'b0) $display("FAIL single_mem_we got=%b exp=0", bus.mem_we); else passes++;
    seen = -1;
    for (int k = 0; k < RL + 3; k++) begin
      settle();
      step_edge();
      if (bus.rvalid[0] && seen < 0) seen = cyc;
      checks++; if (bus.rvalid !== e_rvalid) $display("FAIL single_rvalid cyc=%0d got=%b exp=%b", cyc, bus.rvalid, e_rvalid); else passes++;
      if (e_rvalid[0]) begin
        checks++; if (bus.rdata !== e_rdata) $display("FAIL single_rdata got=%h exp=%h", bus.rdata, e_rdata); else passes++;
      end
    end
    checks++; if (seen !== t0 + 1 + RL) $display("FAIL single_latency got=%0d exp=%0d", seen, t0 + 1 + RL); else passes++;
  endtask

  task automatic test_alternate();
    int rv0;
    logic wrote [8];
    do_reset();
    rv0 = 0;
    for (int a = 0; a < 8; a++) wrote[a] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!p_valid[0]) begin
        p_valid[0] = 1'b1; p_we[0] = 1'b0; p_addr[0] = AW'(20'h100 + $urandom_range(0, 7)); p_wdata[0] = DW'($urandom);
      end
      if (!p_valid[1]) begin
        p_valid[1] = 1'b1; p_we[1] = 1'b1; p_addr[1] = AW'(20'h100 + (k % 8)); p_wdata[1] = 18'h2A5;
        wrote[k % 8] = 1'b1;
      end
      settle();
      checks++; if (bus.gnt !== e_gnt) $display("FAIL alt_gnt cyc=%0d got=%b exp=%b", cyc, bus.gnt, e_gnt); else passes++;
      step_edge();
      if (bus.rvalid[0]) rv0++;
      checks++; if (bus.mem_we !== e_mwe) $display("FAIL alt_mem_we cyc=%0d got=%b exp=%b", cyc, bus.mem_we, e_mwe); else passes++;
      checks++; if (bus.mem_addr !== e_maddr) $display("FAIL alt_mem_addr cyc=%0d got=%h exp=%h", cyc, bus.mem_addr, e_maddr); else passes++;
      checks++; if (bus.rvalid !== e_rvalid) $display("FAIL alt_rvalid cyc=%0d got=%b exp=%b", cyc, bus.rvalid, e_rvalid); else passes++;
      if (e_rvalid != '0) begin
        checks++; if (bus.rdata !== e_rdata) $display("FAIL alt_rdata cyc=%0d got=%h exp=%h", cyc, bus.rdata, e_rdata); else passes++;
      end
    end
    for (int p = 0; p < NP; p++) p_valid[p] = 1'b0;
    for (int k = 0; k < RL + 2; k++) begin
      settle();
      step_edge();
      if (bus.rvalid[0]) rv0++;
    end
    checks++; if (rv0 !== n_gnt[0]) $display("FAIL alt_rvalid_count got=%0d exp=%0d", rv0, n_gnt[0]); else passes++;
    for (int a = 0; a < 8; a++) begin
      if (wrote[a]) begin
        logic [AW-1:0] wa;
        wa = AW'(20'h100 + a);
        checks++; if (sram[wa] !== 18'h2A5) $display("FAIL alt_mem_content addr=%h got=%h exp=2a5", wa, sram[wa]); else passes++;
      end
    end
  endtask

  task automatic test_all_four();
    logic [NP-1:0] one;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      for (int p = 0; p < NP; p++) begin
        if (!p_valid[p]) begin
          p_valid[p] = 1'b1; p_we[p] = 1'b0; p_addr[p] = AW'(20'h200 + p); p_wdata[p] = '0;
        end
      end
      settle();
      checks++; if (bus.gnt !== e_gnt) $display("FAIL four_gnt cyc=%0d got=%b exp=%b", cyc, bus.gnt, e_gnt); else passes++;
      if (k < 5) begin
        one = NP'(1) << (k % NP);
        checks++; if (bus.gnt !== one) $display("FAIL four_order k=%0d got=%b exp=%b", k, bus.gnt, one); else passes++;
      end
      for (int p = 0; p < NP; p++) begin
        if (bus.gnt[p]) begin
          checks++; if (waitc[p] + 1 > NP) $display("FAIL four_fair port=%0d got=%0d exp<=%0d", p, waitc[p] + 1, NP); else passes++;
          waitc[p] = 0;
        end else begin
          waitc[p]++;
        end
      end
      step_edge();
    end
  endtask

  task automatic test_tag_routing();
    int t0, c0, c1;
    do_reset();
    p_valid[1] = 1'b1; p_we[1] = 1'b0; p_addr[1] = 20'h00005; p_wdata[1] = '0;
    settle();
    checks++; if (bus.gnt !== 4'b0010) $display("FAIL tag_gnt1 got=%b exp=0010", bus.gnt); else passes++;
    t0 = cyc;
    step_edge();
    p_valid[0] = 1'b1; p_we[0] = 1'b0; p_addr[0] = 20'h00006; p_wdata[0] = '0;
    settle();
    checks++; if (bus.gnt !== 4'b0001) $display("FAIL tag_gnt0 got=%b exp=0001", bus.gnt); else passes++;
    step_edge();
    c0 = -1; c1 = -1;
    for (int k = 0; k < RL + 2; k++) begin
      settle();
      step_edge();
      if (bus.rvalid[1] && c1 < 0) c1 = cyc;
      if (bus.rvalid[0] && c0 < 0) c0 = cyc;
      checks++; if (bus.rvalid !== e_rvalid) $display("FAIL tag_rvalid cyc=%0d got=%b exp=%b", cyc, bus.rvalid, e_rvalid); else passes++;
      if (e_rvalid != '0) begin
        checks++; if (bus.rdata !== e_rdata) $display("FAIL tag_rdata cyc=%0d got=%h exp=%h", cyc, bus.rdata, e_rdata); else passes++;
      end
    end
    checks++; if (c1 !== t0 + RL + 1) $display("FAIL tag_time1 got=%0d exp=%0d", c1, t0 + RL + 1); else passes++;
    checks++; if (c0 !== t0 + RL + 2) $display("FAIL tag_time0 got=%0d exp=%0d", c0, t0 + RL + 2); else passes++;
  endtask

  task automatic test_reset_midflight();
    int stray;
    do_reset();
    p_valid[0] = 1'b1; p_we[0] = 1'b0; p_addr[0] = 20'h00033; p_wdata[0] = 18'h3FFFF;
    settle();
    step_edge();
    rst = 1'b1;
    for (int p = 0; p < NP; p++) p_valid[p] = 1'b0;
    drive();
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    model_reset();
    checks++; if (bus.rvalid !== '0) $display("FAIL mid_rvalid got=%b exp=0", bus.rvalid); else passes++;
    checks++; if (bus.rdata !== '0) $display("FAIL mid_rdata got=%h exp=0", bus.rdata); else passes++;
    checks++; if (bus.mem_addr !== '0) $display("FAIL mid_mem_addr got=%h exp=0", bus.mem_addr); else passes++;
    checks++; if (bus.mem_wdata !== '0) $display("FAIL mid_mem_wdata got=%h exp=0", bus.mem_wdata); else passes++;
    checks++; if (bus.mem_we !== 1'b0) $display("FAIL mid_mem_we got=%b exp=0", bus.mem_we); else passes++;
    stray = 0;
    for (int k = 0; k < RL + 3; k++) begin
      settle();
      step_edge();
      if (bus.rvalid != '0) stray++;
    end
    checks++; if (stray !== 0) $display("FAIL mid_stray_rvalid got=%0d exp=0", stray); else passes++;
  endtask

  task automatic test_turnaround();
    logic [NP-1:0] g1, g2;
    logic          we1, we2;
`ifdef SRAM_ARB_TURNAROUND_EN
    g1 = 4'b0000; g2 = 4'b0010; we1 = 1'b0; we2 = 1'b1;
`else
    g1 = 4'b0010; g2 = 4'b0000; we1 = 1'b1; we2 = 1'b0;
`endif
    do_reset();
    p_valid[0] = 1'b1; p_we[0] = 1'b0; p_addr[0] = 20'h00040; p_wdata[0] = '0;
    p_valid[1] = 1'b1; p_we[1] = 1'b1; p_addr[1] = 20'h00041; p_wdata[1] = 18'h155;
    settle();
    checks++; if (bus.gnt !== 4'b0001) $display("FAIL ta_gnt0 got=%b exp=0001", bus.gnt); else passes++;
    step_edge();
    checks++; if (bus.mem_we !== 1'b0) $display("FAIL ta_we0 got=%b exp=0", bus.mem_we); else passes++;
    settle();
    checks++; if (bus.gnt !== g1) $display("FAIL ta_gnt1 got=%b exp=%b", bus.gnt, g1); else passes++;
    step_edge();
    checks++; if (bus.mem_we !== we1) $display("FAIL ta_we1 got=%b exp=%b", bus.mem_we, we1); else passes++;
    settle();
    checks++; if (bus.gnt !== g2) $display("FAIL ta_gnt2 got=%b exp=%b", bus.gnt, g2); else passes++;
    step_edge();
    checks++; if (bus.mem_we !== we2) $display("FAIL ta_we2 got=%b exp=%b", bus.mem_we, we2); else passes++;
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      for (int p = 0; p < NP; p++) begin
        if (!p_valid[p]) begin
          if ($urandom_range(0, 2) == 0) begin
            p_valid[p] = 1'b1; p_we[p] = 1'($urandom_range(0, 1));
            p_addr[p] = AW'($urandom_range(0, 15)); p_wdata[p] = DW'($urandom);
            waitc[p] = 0;
          end
        end else if ($urandom_range(0, 19) == 0) begin
          p_valid[p] = 1'b0;
          waitc[p] = 0;
        end
      end
      settle();
      checks++; if (bus.gnt !== e_gnt) $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, bus.gnt, e_gnt); else passes++;
      for (int p = 0; p < NP; p++) begin
        if (p_valid[p]) begin
          if (bus.gnt[p]) begin
            checks++; if (waitc[p] + 1 > FAIR) $display("FAIL rnd_fair port=%0d got=%0d exp<=%0d", p, waitc[p] + 1, FAIR); else passes++;
            waitc[p] = 0;
          end else begin
            waitc[p]++;
          end
        end
      end
      step_edge();
      checks++; if (bus.mem_we !== e_mwe) $display("FAIL rnd_mem_we cyc=%0d got=%b exp=%b", cyc, bus.mem_we, e_mwe); else passes++;
      checks++; if (bus.mem_addr !== e_maddr) $display("FAIL rnd_mem_addr cyc=%0d got=%h exp=%h", cyc, bus.mem_addr, e_maddr); else passes++;
      checks++; if (bus.mem_wdata !== e_mwdata) $display("FAIL rnd_mem_wdata cyc=%0d got=%h exp=%h", cyc, bus.mem_wdata, e_mwdata); else passes++;
      checks++; if (bus.rvalid !== e_rvalid) $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", cyc, bus.rvalid, e_rvalid); else passes++;
      if (e_rvalid != '0) begin
        checks++; if (bus.rdata !== e_rdata) $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, bus.rdata, e_rdata); else passes++;
      end
    end
  endtask

  initial begin
    for (int p = 0; p < NP; p++) begin
      p_valid[p] = 1'b0; p_we[p] = 1'b0; p_addr[p] = '0; p_wdata[p] = '0;
    end
    model_reset();
    test_reset();
    test_single_read();
    test_alternate();
    test_all_four();
    test_tag_routing();
    test_reset_midflight();
    test_turnaround();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
`default_nettype wire
